// File: rtl/alu_pkg.sv
// Shared encodings for the OR/SUB ALU port: opcodes, one-hot ALU selects,
// flag bit positions, sequencer states and the queued request record.
package alu_pkg;

    localparam logic OP_OR  = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] ALU_SEL_OR   = 2'b10;
    localparam logic [1:0] ALU_SEL_SUB  = 2'b01;
    localparam logic [1:0] ALU_SEL_NONE = 2'b00;

    localparam int unsigned FLAG_OVF  = 1;
    localparam int unsigned FLAG_SIGN = 0;

    localparam int unsigned REQ_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_req_t;

    function automatic logic [1:0] op_to_sel(input logic op);
        return (op == OP_SUB) ? ALU_SEL_SUB : ALU_SEL_OR;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request queue for the ALU sequencer: DEPTH x REQ_W synchronous FIFO.
// Writes while full and reads while empty are ignored.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REQ_W-1:0] push_data,
    input  logic             pop,
    output logic [REQ_W-1:0] pop_data,
    output logic             full,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push_en;
    logic             pop_en;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign push_en  = push && !full;
    assign pop_en   = pop && (count_q != '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_req_sequencer.sv
// Initiator for the combinational OR/SUB ALU: queues requests, issues them one
// at a time, returns {result, overflow, sign} and keeps a sticky overflow flag.
module alu_req_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [1:0] alu_operation,
    output logic [7:0] alu_operand_0,
    output logic [7:0] alu_operand_1,
    input  logic [7:0] alu_result,
    input  logic [1:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [1:0] rsp_flags,
    output logic       sticky_ovf,
    input  logic       sticky_clr
);

    seq_state_e state_q, state_d;
    alu_req_t   iss_q, iss_d;
    alu_req_t   fifo_data;
    alu_req_t   push_req;
    logic       fifo_full;
    logic       fifo_pop;
    logic       fifo_has_req;
    logic [PTR_W:0] fifo_count;

    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic [1:0] rsp_flags_q, rsp_flags_d;
    logic       sticky_q, sticky_d;
    logic       cap_ovf;

    assign push_req = '{op: req_op, a: req_a, b: req_b};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Ready depends only on registered occupancy, never on rsp_ready.
    assign req_ready    = !fifo_full;
    assign fifo_has_req = (fifo_count != '0);

    always_comb begin
        state_d      = state_q;
        iss_d        = iss_q;
        fifo_pop     = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        sticky_d     = sticky_clr ? 1'b0 : sticky_q;
        cap_ovf      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fifo_has_req) begin
                    fifo_pop = 1'b1;
                    iss_d    = fifo_data;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Overflow carries no meaning for OR, so it is masked here.
                cap_ovf                = (iss_q.op == OP_SUB) && alu_flags[FLAG_OVF];
                rsp_result_d           = alu_result;
                rsp_flags_d[FLAG_OVF]  = cap_ovf;
                rsp_flags_d[FLAG_SIGN] = alu_flags[FLAG_SIGN];
                rsp_valid_d            = 1'b1;
                sticky_d               = sticky_clr ? cap_ovf : (sticky_q | cap_ovf);
                state_d                = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (fifo_has_req) begin
                        fifo_pop = 1'b1;
                        iss_d    = fifo_data;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_operation = ALU_SEL_NONE;
        alu_operand_0 = '0;
        alu_operand_1 = '0;
        if (state_q == ISSUE) begin
            alu_operation = op_to_sel(iss_q.op);
            alu_operand_0 = iss_q.a;
            alu_operand_1 = iss_q.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            iss_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            iss_q        <= iss_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            sticky_q     <= sticky_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Bench for alu_req_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_alu_req_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_op;
    logic [7:0] req_a, req_b;
    logic [1:0] alu_operation;
    logic [7:0] alu_operand_0, alu_operand_1;
    logic [7:0] alu_result;
    logic [1:0] alu_flags;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic [1:0] rsp_flags;
    logic       sticky_ovf, sticky_clr;

    alu_req_sequencer #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .alu_operation (alu_operation),
        .alu_operand_0 (alu_operand_0),
        .alu_operand_1 (alu_operand_1),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .sticky_ovf    (sticky_ovf),
        .sticky_clr    (sticky_clr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; drives junk when idle and a junk overflow bit for OR.
    logic [7:0] junk;
    always @(posedge clk) junk <= 8'($urandom);

    always_comb begin
        alu_result = junk;
        alu_flags  = junk[1:0];
        if (alu_operation == 2'b01) begin
            alu_result   = alu_operand_0 - alu_operand_1;
            alu_flags[1] = (alu_operand_0[7] != alu_operand_1[7]) &&
                           (alu_result[7] != alu_operand_0[7]);
            alu_flags[0] = alu_result[7];
        end else if (alu_operation == 2'b10) begin
            alu_result   = alu_operand_0 | alu_operand_1;
            alu_flags[1] = junk[0];
            alu_flags[0] = alu_result[7];
        end
    end

    // Reference model: queued requests, the request being worked on, and
    // where that request is (0 none, 1 at the ALU, 2 response waiting).
    typedef struct packed {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    req_t       m_q[$];
    req_t       m_cur;
    int         m_stage;
    logic       m_rv;
    logic [7:0] m_res;
    logic [1:0] m_flg;
    logic       m_sticky;

    int vectors = 0;
    int miscompares = 0;
    int accepted = 0;
    int responses = 0;
    int cyc = 0;
    int rsp_cycles[$];

    function automatic logic [7:0] ref_result(input req_t r);
        return r.op ? 8'(r.a - r.b) : (r.a | r.b);
    endfunction

    function automatic logic ref_ovf(input req_t r);
        int sa, sb, d;
        sa = $signed(r.a);
        sb = $signed(r.b);
        d  = sa - sb;
        return r.op && (d > 127 || d < -128);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur    = '0;
        m_stage  = 0;
        m_rv     = 1'b0;
        m_res    = '0;
        m_flg    = '0;
        m_sticky = 1'b0;
    endtask

    task automatic model_step();
        bit   enq, pop;
        logic ovf;
        int   nxt;
        if (rst) begin
            model_reset();
            return;
        end
        enq = req_valid && (m_q.size() < DEPTH);
        pop = (m_q.size() > 0) && (m_stage == 0 || (m_stage == 2 && rsp_ready));
        nxt = m_stage;
        if (m_stage == 1) begin
            ovf      = ref_ovf(m_cur);
            m_res    = ref_result(m_cur);
            m_flg    = {ovf, m_res[7]};
            m_rv     = 1'b1;
            m_sticky = sticky_clr ? ovf : (m_sticky | ovf);
            nxt      = 2;
        end else begin
            if (sticky_clr) m_sticky = 1'b0;
            if (m_stage == 0) nxt = pop ? 1 : 0;
            if (m_stage == 2 && rsp_ready) begin
                m_rv = 1'b0;
                nxt  = pop ? 1 : 0;
            end
        end
        m_stage = nxt;
        if (pop) m_cur = m_q.pop_front();
        if (enq) m_q.push_back('{op: req_op, a: req_a, b: req_b});
    endtask

    // One clock: compare at the falling edge, advance the model, then move
    // just past the rising edge so callers can drive the next inputs.
    task automatic tick();
        @(negedge clk);
        check("req_ready", req_ready, m_q.size() < DEPTH);
        check("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            check("rsp_result", rsp_result, m_res);
            check("rsp_flags", rsp_flags, m_flg);
        end
        check("alu_operation", alu_operation,
              (m_stage == 1) ? (m_cur.op ? 2'b01 : 2'b10) : 2'b00);
        if (m_stage == 1) begin
            check("alu_operand_0", alu_operand_0, m_cur.a);
            check("alu_operand_1", alu_operand_1, m_cur.b);
        end
        check("sticky_ovf", sticky_ovf, m_sticky);
        if (req_valid && req_ready) accepted++;
        if (rsp_valid && rsp_ready) begin
            responses++;
            rsp_cycles.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [1:0] flg;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   guard, base, acc0;
        logic op;

        tbl[0] = '{op: 1'b1, a: 8'h05, b: 8'h03, res: 8'h02, flg: 2'b00};
        tbl[1] = '{op: 1'b1, a: 8'h80, b: 8'h01, res: 8'h7F, flg: 2'b10};
        tbl[2] = '{op: 1'b0, a: 8'hF0, b: 8'h0F, res: 8'hFF, flg: 2'b01};
        tbl[3] = '{op: 1'b1, a: 8'h00, b: 8'h01, res: 8'hFF, flg: 2'b01};
        tbl[4] = '{op: 1'b1, a: 8'h7F, b: 8'hFF, res: 8'h80, flg: 2'b11};
        tbl[5] = '{op: 1'b0, a: 8'h00, b: 8'h00, res: 8'h00, flg: 2'b00};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; sticky_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        rst = 1'b0;
        check("reset_rsp_result", rsp_result, 8'h00);
        check("reset_rsp_flags", rsp_flags, 2'b00);
        check("reset_operand_0", alu_operand_0, 8'h00);

        // Directed table: latency N+3, one-cycle issue, captured values.
        foreach (tbl[i]) begin
            req_valid = 1'b1; req_op = tbl[i].op; req_a = tbl[i].a; req_b = tbl[i].b;
            tick();
            req_valid = 1'b0;
            check("tbl_n1_op", alu_operation, 2'b00);
            check("tbl_n1_valid", rsp_valid, 1'b0);
            tick();
            check("tbl_n2_op", alu_operation, tbl[i].op ? 2'b01 : 2'b10);
            check("tbl_n2_a", alu_operand_0, tbl[i].a);
            tick();
            check("tbl_n3_valid", rsp_valid, 1'b1);
            check("tbl_n3_result", rsp_result, tbl[i].res);
            check("tbl_n3_flags", rsp_flags, tbl[i].flg);
            tick();
            check("tbl_n4_valid", rsp_valid, 1'b0);
            check("tbl_n4_op", alu_operation, 2'b00);
        end
        check("sticky_set", sticky_ovf, 1'b1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("sticky_cleared", sticky_ovf, 1'b0);

        // Stall with a full queue; the sixth request waits for a drain.
        rsp_ready = 1'b0;
        acc0 = accepted;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_op = 1'b1; req_a = 8'(8'h10 + i); req_b = 8'(i);
            tick();
        end
        check("full_accepted", accepted - acc0, 5);
        check("full_ready", req_ready, 1'b0);
        repeat (3) tick();
        check("full_still_blocked", accepted - acc0, 5);
        rsp_ready = 1'b1;
        guard = 0;
        while (accepted - acc0 < 6 && guard < 10) begin
            tick();
            guard++;
        end
        check("sixth_accepted", accepted - acc0, 6);
        req_valid = 1'b0;
        repeat (16) tick();

        // Reset while a request is at the ALU with three more queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 1'(i); req_a = 8'(8'hA0 + i); req_b = 8'h11;
            tick();
        end
        req_valid = 1'b0;
        guard = 0;
        while (!(m_stage == 2 && m_q.size() == 4) && guard < 10) begin
            tick();
            guard++;
        end
        check("rst_setup_reached", guard < 10, 1'b1);
        rsp_ready = 1'b1;
        tick();
        check("rst_in_issue", alu_operation != 2'b00, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_alu_op", alu_operation, 2'b00);
        check("rst_req_ready", req_ready, 1'b1);
        base = responses;
        repeat (10) tick();
        check("rst_no_stale_rsp", responses - base, 0);

        // Back-to-back alternating stream: one response every two cycles.
        rsp_ready = 1'b1;
        rsp_cycles.delete();
        base = responses;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_op = 1'(i % 2); req_a = 8'($urandom); req_b = 8'($urandom);
            acc0 = accepted;
            guard = 0;
            do begin
                tick();
                guard++;
            end while (accepted == acc0 && guard < 10);
        end
        req_valid = 1'b0;
        guard = 0;
        while (responses - base < 8 && guard < 30) begin
            tick();
            guard++;
        end
        check("stream_count", responses - base, 8);
        for (int i = 1; i < rsp_cycles.size(); i++)
            check("stream_gap", rsp_cycles[i] - rsp_cycles[i-1], 2);

        // Randomized traffic, including coincident clear/capture and resets.
        for (int i = 0; i < 1500; i++) begin
            op         = 1'($urandom);
            req_valid  = 1'($urandom);
            req_op     = op;
            req_a      = 8'($urandom);
            req_b      = 8'($urandom);
            rsp_ready  = ($urandom % 4) != 0;
            sticky_clr = ($urandom % 8) == 0;
            rst        = ($urandom % 200) == 0;
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; sticky_clr = 1'b0; rsp_ready = 1'b1;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
